// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP sequencer and its datapath: FSM states and
// the weight-word slice positions.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    FIRE    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  // Layer weights inside the 128-bit bridge word; the upper 64 bits are unused.
  localparam int W1_LSB = 0;
  localparam int W1_MSB = 31;
  localparam int W2_LSB = 32;
  localparam int W2_MSB = 63;

  localparam int ACT_W = 16;

endpackage

// File: rtl/mlp_fetch_timer.sv
// Loadable down-counter bounding the wait for a bridge read acknowledge.
// done is high whenever the count sits at zero.
module mlp_fetch_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   count <= '0;
    else if (clear)            count <= '0;
    else if (load)             count <= load_val;
    else if (en && count != 0) count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/mlp_sequencer.sv
// Request sequencer for the 2-2-2 MLP datapath: caches the weight word read
// once from the bridge, then fires the datapath per request and returns dp_out.
module mlp_sequencer
  import mlp_pkg::*;
#(
  parameter int                           INTERFACE_WIDTH_BITS = 128,
  parameter int                           INTERFACE_ADDR_BITS  = 26,
  parameter logic [INTERFACE_ADDR_BITS-1:0] WEIGHT_ADDR        = '0,
  parameter int                           TIMEOUT_CYCLES       = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ACT_W-1:0]                req_in,
  input  logic                            reload,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ACT_W-1:0]                rsp_out,
  output logic                            rsp_err,
  output logic                            rd_req,
  output logic [INTERFACE_ADDR_BITS-1:0]  rd_addr,
  input  logic                            rd_ack,
  input  logic [INTERFACE_WIDTH_BITS-1:0] rd_data,
  output logic [INTERFACE_WIDTH_BITS-1:0] dp_data,
  output logic [ACT_W-1:0]                dp_in,
  output logic                            dp_ack,
  input  logic [ACT_W-1:0]                dp_out
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_START = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, next;
  logic          cache_vld;
  logic          accept, fetch_ack, timeout, capture;
  logic          tmr_load, tmr_clear, tmr_done;
  logic [TW-1:0] tmr_count;

  mlp_fetch_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .en       (state == FETCH),
    .load_val (TMR_START),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next      = state;
    accept    = 1'b0;
    fetch_ack = 1'b0;
    timeout   = 1'b0;
    capture   = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          // a reload arriving with the request forces a refetch
          if (cache_vld && !reload) begin
            next = FIRE;
          end else begin
            next     = FETCH;
            tmr_load = 1'b1;
          end
        end
      end
      FETCH: begin
        if (rd_ack) begin
          fetch_ack = 1'b1;
          tmr_clear = 1'b1;
          next      = FIRE;
        end else if (tmr_done) begin
          timeout = 1'b1;
          next    = RESP;
        end
      end
      FIRE:    next = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        next    = RESP;
      end
      RESP:    if (rsp_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // dp_in/dp_data only change on accept/fetch, so they hold through FIRE and CAPTURE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_vld <= 1'b0;
      dp_data   <= '0;
      dp_in     <= '0;
      rsp_out   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept)    dp_in   <= req_in;
      if (fetch_ack) dp_data <= rd_data;
      if (reload)         cache_vld <= 1'b0;
      else if (fetch_ack) cache_vld <= 1'b1;
      if (capture) begin
        rsp_out <= dp_out;
        rsp_err <= 1'b0;
      end else if (timeout) begin
        rsp_out <= '0;
        rsp_err <= 1'b1;
      end
    end
  end

  // req_ready is masked by reset so every output reads 0 while reset is held.
  assign req_ready = (state == IDLE) && !reset;
  assign rsp_valid = (state == RESP);
  assign rd_req    = (state == FETCH);
  assign rd_addr   = rd_req ? WEIGHT_ADDR : '0;
  assign dp_ack    = (state == FIRE);

endmodule

// File: tb/tb_mlp_sequencer.sv
// Bench for mlp_sequencer: directed vector table, hand-written corner sequences
// and randomized requests against a cache-level reference model.
module tb_mlp_sequencer;
  import mlp_pkg::*;

  localparam int          TW    = 8;
  localparam logic [25:0] WADDR = 26'h2ABCDE0;

  logic         clk = 1'b0;
  logic         reset, req_valid, req_ready, reload, rsp_valid, rsp_ready, rsp_err;
  logic         rd_req, rd_ack, dp_ack;
  logic [15:0]  req_in, rsp_out, dp_in, dp_out;
  logic [25:0]  rd_addr;
  logic [127:0] rd_data, dp_data;

  mlp_sequencer #(
    .INTERFACE_WIDTH_BITS (128),
    .INTERFACE_ADDR_BITS  (26),
    .WEIGHT_ADDR          (WADDR),
    .TIMEOUT_CYCLES       (TW)
  ) dut (
    .clk (clk), .reset (reset),
    .req_valid (req_valid), .req_ready (req_ready), .req_in (req_in),
    .reload (reload),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_out (rsp_out), .rsp_err (rsp_err),
    .rd_req (rd_req), .rd_addr (rd_addr), .rd_ack (rd_ack), .rd_data (rd_data),
    .dp_data (dp_data), .dp_in (dp_in), .dp_ack (dp_ack), .dp_out (dp_out)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // 2-2-2 network, 8-bit wraparound; weights w[layer][out][in] byte-packed.
  function automatic logic [15:0] mlp_ref(input logic [15:0] x, input logic [63:0] w);
    int a[2];
    int h[2];
    int o[2];
    a[0] = int'(x[7:0]);
    a[1] = int'(x[15:8]);
    for (int j = 0; j < 2; j++)
      h[j] = (a[0] * int'(w[j*16 +: 8]) + a[1] * int'(w[j*16+8 +: 8])) % 256;
    for (int k = 0; k < 2; k++)
      o[k] = (h[0] * int'(w[32+k*16 +: 8]) + h[1] * int'(w[32+k*16+8 +: 8])) % 256;
    return {o[1][7:0], o[0][7:0]};
  endfunction

  // Stand-in datapath: result is only meaningful the cycle after dp_ack.
  always @(posedge clk) begin
    if (dp_ack) dp_out <= mlp_ref(dp_in, {dp_data[W2_MSB:W2_LSB], dp_data[W1_MSB:W1_LSB]});
    else        dp_out <= 16'($urandom);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ctl"}, {req_ready, rsp_valid, rsp_err, rd_req, dp_ack}, 0);
    chk({tag, " data"}, {rsp_out, dp_in, rd_addr}, 0);
    chk({tag, " dp_data"}, dp_data, 0);
  endtask

  typedef struct {
    logic [15:0] rin;
    int          dly;      // fetch cycle index carrying rd_ack; >= TW never acks
    int          rl_mode;  // 0 none, 1 reload pulse before, 2 reload with accept
    bit          rl_ack;   // reload coincident with rd_ack
    bit          late;     // rd_ack after the response (RESP and IDLE)
    logic [15:0] exp_out;
    bit          exp_err;
    int          exp_fetch;
    int          exp_lat;
  } vec_t;

  logic [127:0] bridge_word;
  bit           ref_valid;
  logic [127:0] ref_word;

  task automatic run_req(input vec_t v, output logic [15:0] out, output bit err,
                         output int nfetch, output int lat, output int nack);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (v.rl_mode == 1) begin
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
    end
    req_valid = 1'b1;
    req_in    = v.rin;
    reload    = (v.rl_mode == 2);
    @(negedge clk);
    req_valid = 1'b0;
    reload    = 1'b0;
    req_in    = 16'($urandom);
    lat = 1; nfetch = 0; nack = 0;
    while (!rsp_valid && lat < 64) begin
      if (dp_ack) nack++;
      if (rd_req) begin
        chk("rd_addr", rd_addr, WADDR);
        if (nfetch == v.dly) begin
          rd_ack  = 1'b1;
          rd_data = bridge_word;
          reload  = v.rl_ack;
        end
        nfetch++;
      end
      @(negedge clk);
      rd_ack  = 1'b0;
      reload  = 1'b0;
      rd_data = {$urandom, $urandom, $urandom, $urandom};
      lat++;
    end
    chk("rsp_valid_seen", rsp_valid, 1);
    out = rsp_out;
    err = rsp_err;
    if (v.late) begin
      rd_ack  = 1'b1;
      rd_data = ~bridge_word;
    end
    @(negedge clk);
    if (v.late) begin
      @(negedge clk);
      rd_ack = 1'b0;
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [15:0] out;
    bit          err;
    int          nfetch, lat, nack;
    run_req(v, out, err, nfetch, lat, nack);
    chk({tag, " rsp_out"}, out, v.exp_out);
    chk({tag, " rsp_err"}, err, v.exp_err);
    chk({tag, " fetch_cycles"}, nfetch, v.exp_fetch);
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " dp_ack_pulses"}, nack, v.exp_err ? 0 : 1);
  endtask

  // Cache-level model: hit -> 3 cycles; miss -> ack index + 4; no ack -> error.
  task automatic model_req(input logic [15:0] rin, input int dly, input int rl_mode,
                           input bit rl_ack, input string tag);
    vec_t v;
    if (rl_mode != 0) ref_valid = 1'b0;
    v = '{rin, dly, rl_mode, rl_ack, 1'b0, 16'h0, 1'b0, 0, 0};
    if (ref_valid) begin
      v.exp_out = mlp_ref(rin, ref_word[63:0]);
      v.exp_lat = 3;
    end else if (dly >= TW) begin
      v.exp_err   = 1'b1;
      v.exp_fetch = TW;
      v.exp_lat   = TW + 1;
    end else begin
      ref_word    = bridge_word;
      ref_valid   = !rl_ack;
      v.exp_out   = mlp_ref(rin, bridge_word[63:0]);
      v.exp_fetch = dly + 1;
      v.exp_lat   = dly + 4;
    end
    apply(v, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[8];
    logic [15:0] held, a_in, b_in;
    int          guard;

    reset = 1'b1; req_valid = 1'b0; req_in = '0; rsp_ready = 1'b1;
    reload = 1'b0; rd_ack = 1'b0; rd_data = '0;
    bridge_word = {64'hDEADBEEF_CAFEF00D, 32'h08070605, 32'h04030201};

    tbl[0] = '{16'h0201, 3,  0, 1'b0, 1'b0, 16'h7B5B, 1'b0, 4, 7};  // cold
    tbl[1] = '{16'h0102, 0,  0, 1'b0, 1'b0, 16'h6C50, 1'b0, 0, 3};  // warm
    tbl[2] = '{16'h0303, 0,  1, 1'b0, 1'b0, mlp_ref(16'h0303, bridge_word[63:0]), 1'b0, 1, 4};
    tbl[3] = '{16'h0403, 1,  2, 1'b1, 1'b0, mlp_ref(16'h0403, bridge_word[63:0]), 1'b0, 2, 5};
    tbl[4] = '{16'h0505, 0,  0, 1'b0, 1'b0, mlp_ref(16'h0505, bridge_word[63:0]), 1'b0, 1, 4};
    tbl[5] = '{16'hFFFF, 0,  0, 1'b0, 1'b0, mlp_ref(16'hFFFF, bridge_word[63:0]), 1'b0, 0, 3};
    tbl[6] = '{16'h1234, 99, 1, 1'b0, 1'b1, 16'h0000, 1'b1, TW, TW + 1};  // timeout + late ack
    tbl[7] = '{16'h0201, 2,  0, 1'b0, 1'b0, 16'h7B5B, 1'b0, 3, 6};

    #12;
    chk_zero("reset_hold");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset req_ready", req_ready, 1);
    chk("post_reset rsp_valid", rsp_valid, 0);

    for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("vec%0d", i));
    ref_valid = 1'b1;
    ref_word  = bridge_word;

    // Backpressure: response held five cycles, next request waits in IDLE.
    a_in = 16'h0A0B; b_in = 16'h3C2D;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_in = a_in;
    @(negedge clk);
    req_in = b_in;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    held = rsp_out;
    chk("bp rsp_out", held, mlp_ref(a_in, ref_word[63:0]));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp stall%0d", i), {rsp_valid, req_ready, rsp_out, dp_in}, {1'b1, 1'b0, held, a_in});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp idle after handshake", {req_ready, rsp_valid}, 2'b10);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp accepted next cycle", {dp_ack, req_ready, dp_in}, {1'b1, 1'b0, b_in});
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("bp second rsp_out", {rsp_valid, rsp_out}, {1'b1, mlp_ref(b_in, ref_word[63:0])});
    @(negedge clk);

    // Reset during FETCH.
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0; req_valid = 1'b1; req_in = 16'h7777;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_fetch in fetch", rd_req, 1);
    reset = 1'b1;
    #1;
    chk_zero("rst_fetch");
    @(negedge clk);
    reset = 1'b0;
    ref_valid = 1'b0;
    bridge_word = {$urandom, $urandom, $urandom, $urandom};
    model_req(16'h0607, 1, 0, 1'b0, "after_rst_fetch");

    // Reset during RESP.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_in = 16'h1111;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_resp in resp", rsp_valid, 1);
    reset = 1'b1;
    #1;
    chk_zero("rst_resp");
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    ref_valid = 1'b0;
    model_req(16'h0809, 0, 0, 1'b0, "after_rst_resp");

    // Randomized traffic against the cache model.
    for (int i = 0; i < 30; i++) begin
      int r, dly, mode;
      bridge_word = {$urandom, $urandom, $urandom, $urandom};
      r    = $urandom_range(0, 9);
      dly  = (r == 9) ? 50 : r % 5;
      mode = $urandom_range(0, 3);
      if (mode == 3) mode = 0;
      model_req(16'($urandom), dly, mode, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
